// File: rtl/fnn_pkg.sv
// Shared defaults and FSM state type for the FNN sample loader.
package fnn_pkg;

    localparam int FNN_NUM_BYTES   = 62;
    localparam int FNN_ADDR_W      = 10;
    localparam int FNN_NUM_SAMPLES = 750;
    localparam int FNN_LABEL_MAX   = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_LABEL,
        S_WRITE,
        S_DONE
    } loader_state_t;

endpackage

// File: rtl/fnn_byte_assembler.sv
// Byte counter plus byte-indexed image register; byte k lands in bits [8k+7:8k].
// last_byte_o flags that the next accepted byte completes the image; counter wraps to 0 on it.
module fnn_byte_assembler
    import fnn_pkg::*;
#(
    parameter int NUM_BYTES = FNN_NUM_BYTES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_i,
    input  logic                   accept_i,
    input  logic [7:0]             byte_i,
    output logic [NUM_BYTES*8-1:0] image_o,
    output logic                   last_byte_o
);

    localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_BYTES*8-1:0] image_q, image_d;

    assign last_byte_o = (cnt_q == CNT_W'(NUM_BYTES - 1));
    assign image_o     = image_q;

    always_comb begin
        cnt_d   = cnt_q;
        image_d = image_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (accept_i) begin
            image_d[int'(cnt_q)*8 +: 8] = byte_i;
            cnt_d = last_byte_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            image_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            image_q <= image_d;
        end
    end

endmodule

// File: rtl/fnn_sample_loader.sv
// Streams NUM_BYTES image bytes + 1 label byte per sample and issues one memory write each (64 cycles/sample back-to-back).
// in_ready is registered from state only; FNN_LOADER_LABEL_CHECK_EN drops samples whose label byte exceeds 9 and sets sticky err.
module fnn_sample_loader
    import fnn_pkg::*;
#(
    parameter int NUM_BYTES   = FNN_NUM_BYTES,
    parameter int ADDR_W      = FNN_ADDR_W,
    parameter int NUM_SAMPLES = FNN_NUM_SAMPLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   mem_write,
    output logic [ADDR_W-1:0]      mem_adr,
    output logic [NUM_BYTES*8-1:0] data_wdata,
    output logic [3:0]             label_wdata,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    loader_state_t     state_q;
    logic              in_ready_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] adr_q;
    logic [3:0]        label_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic accept;
    logic collect_accept;
    logic clear;
    logic last_byte;
    logic label_bad;

    assign accept         = in_valid & in_ready_q;
    assign collect_accept = accept & (state_q == S_COLLECT);
    assign clear          = start & ((state_q == S_IDLE) | (state_q == S_DONE));

`ifdef FNN_LOADER_LABEL_CHECK_EN
    assign label_bad = (in_data > 8'(FNN_LABEL_MAX));
`else
    assign label_bad = 1'b0;
`endif

    fnn_byte_assembler #(
        .NUM_BYTES (NUM_BYTES)
    ) u_asm (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear),
        .accept_i    (collect_accept),
        .byte_i      (in_data),
        .image_o     (data_wdata),
        .last_byte_o (last_byte)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            mem_write_q <= 1'b0;
            adr_q       <= '0;
            label_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_write_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q    <= S_COLLECT;
                        adr_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (collect_accept && last_byte) begin
                        state_q <= S_LABEL;
                    end
                end
                S_LABEL: begin
                    // A rejected label leaves in_ready high: the next byte starts a fresh image at the same address.
                    if (accept) begin
                        if (label_bad) begin
                            err_q   <= 1'b1;
                            state_q <= S_COLLECT;
                        end else begin
                            label_q     <= in_data[3:0];
                            state_q     <= S_WRITE;
                            in_ready_q  <= 1'b0;
                            mem_write_q <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (adr_q == ADDR_W'(NUM_SAMPLES - 1)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        adr_q      <= adr_q + ADDR_W'(1);
                        state_q    <= S_COLLECT;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign mem_write   = mem_write_q;
    assign mem_adr     = adr_q;
    assign label_wdata = label_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
